// File: rtl/me_sad_min_search_pkg.sv
// Shared constants and helpers for the SAD minimum-search block.
// Geometry: 8 rows x 16 pixels of 8 bits per block; row sums fit 12 bits, block totals 15 bits.
package me_sad_min_search_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned ROW_PIX  = 16;
    localparam int unsigned BLK_ROWS = 8;
    localparam int unsigned SAD_W    = 15;
    localparam int unsigned ROWSUM_W = 12;
    localparam int unsigned ROW_W    = PIX_W * ROW_PIX;

    typedef logic [ROW_W-1:0] row_t;

    // Absolute difference of two unsigned pixels.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/me_row_sad.sv
// Per-row combinational SAD helper.
// Ports:
//   ref_row_i  - candidate row (16 pixels, pixel 0 in bits [7:0])
//   cur_row_i  - current-block row
//   diff_row_i - registered per-pixel differences to be summed
//   diff_o     - per-pixel |ref - cur| for this row
//   sum_o      - sum of the 16 pixels of diff_row_i
// The difference and the summation sit on opposite sides of the S1 register, so the two halves
// take independent inputs; the top keeps both pipeline registers.
module me_row_sad
    import me_sad_min_search_pkg::*;
(
    input  logic [ROW_W-1:0]    ref_row_i,
    input  logic [ROW_W-1:0]    cur_row_i,
    input  logic [ROW_W-1:0]    diff_row_i,
    output logic [ROW_W-1:0]    diff_o,
    output logic [ROWSUM_W-1:0] sum_o
);

    always_comb begin
        diff_o = '0;
        sum_o  = '0;
        for (int p = 0; p < ROW_PIX; p++) begin
            diff_o[p*PIX_W +: PIX_W] = abs_diff(ref_row_i[p*PIX_W +: PIX_W],
                                                cur_row_i[p*PIX_W +: PIX_W]);
            sum_o = sum_o + ROWSUM_W'(diff_row_i[p*PIX_W +: PIX_W]);
        end
    end

endmodule

// File: rtl/me_sad_min_search.sv
// 3-stage SAD pipeline with minimum-SAD search over a stream of candidate blocks.
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-high reset
//   cur_wr_i/addr_i/row_i     - write one row of the stored current block
//   start_i                   - begin a new search (flushes in-flight results)
//   valid_i, last_i           - candidate valid / last candidate of the search
//   ref_row0_i..ref_row7_i    - candidate rows
//   sad_valid_o, sad_o        - per-candidate SAD, 3 cycles after valid_i
//   done_o                    - one-cycle pulse, 4 cycles after the last candidate
//   best_sad_o, best_idx_o    - minimum SAD and its index for the finished search
module me_sad_min_search
    import me_sad_min_search_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cur_wr_i,
    input  logic [2:0]       cur_addr_i,
    input  logic [ROW_W-1:0] cur_row_i,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic [ROW_W-1:0] ref_row0_i,
    input  logic [ROW_W-1:0] ref_row1_i,
    input  logic [ROW_W-1:0] ref_row2_i,
    input  logic [ROW_W-1:0] ref_row3_i,
    input  logic [ROW_W-1:0] ref_row4_i,
    input  logic [ROW_W-1:0] ref_row5_i,
    input  logic [ROW_W-1:0] ref_row6_i,
    input  logic [ROW_W-1:0] ref_row7_i,
    output logic             sad_valid_o,
    output logic [SAD_W-1:0] sad_o,
    output logic             done_o,
    output logic [SAD_W-1:0] best_sad_o,
    output logic [IDX_W-1:0] best_idx_o
);

    row_t                cur_q     [BLK_ROWS];
    row_t                ref_rows  [BLK_ROWS];
    row_t                diff_d    [BLK_ROWS];
    row_t                s1_diff_q [BLK_ROWS];
    logic [ROWSUM_W-1:0] rowsum_d  [BLK_ROWS];
    logic [ROWSUM_W-1:0] s2_sum_q  [BLK_ROWS];
    logic [SAD_W-1:0]    total_d, s3_sad_q;

    logic                s1_v_q, s2_v_q, s3_v_q;
    logic                s1_last_q, s2_last_q, s3_last_q;
    logic [IDX_W-1:0]    s1_idx_q, s2_idx_q, s3_idx_q;
    logic [IDX_W-1:0]    idx_q, idx_d, cand_idx;

    logic                first_q, take;
    logic [SAD_W-1:0]    min_sad_q, cmp_sad, best_sad_q;
    logic [IDX_W-1:0]    min_idx_q, cmp_idx, best_idx_q;
    logic                done_q;

    assign ref_rows[0] = ref_row0_i;
    assign ref_rows[1] = ref_row1_i;
    assign ref_rows[2] = ref_row2_i;
    assign ref_rows[3] = ref_row3_i;
    assign ref_rows[4] = ref_row4_i;
    assign ref_rows[5] = ref_row5_i;
    assign ref_rows[6] = ref_row6_i;
    assign ref_rows[7] = ref_row7_i;

    for (genvar r = 0; r < BLK_ROWS; r++) begin : g_row
        me_row_sad u_row_sad (
            .ref_row_i  (ref_rows[r]),
            .cur_row_i  (cur_q[r]),
            .diff_row_i (s1_diff_q[r]),
            .diff_o     (diff_d[r]),
            .sum_o      (rowsum_d[r])
        );
    end

    always_comb begin
        total_d = '0;
        for (int r = 0; r < BLK_ROWS; r++) begin
            total_d = total_d + SAD_W'(s2_sum_q[r]);
        end
    end

    // A candidate arriving with start_i is index 0 of the new search.
    always_comb begin
        cand_idx = start_i ? '0 : idx_q;
        idx_d    = cand_idx + IDX_W'(valid_i);
    end

    // Strict less-than keeps the earlier index on ties.
    always_comb begin
        take    = s3_v_q && (first_q || (s3_sad_q < min_sad_q));
        cmp_sad = take ? s3_sad_q : min_sad_q;
        cmp_idx = take ? s3_idx_q : min_idx_q;
    end

    // Writes land at the edge, so a candidate in the same cycle still sees the old row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < BLK_ROWS; r++) cur_q[r] <= '0;
        end else if (cur_wr_i) begin
            cur_q[cur_addr_i] <= cur_row_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s2_last_q <= 1'b0;
            s3_last_q <= 1'b0;
            s1_idx_q  <= '0;
            s2_idx_q  <= '0;
            s3_idx_q  <= '0;
            s3_sad_q  <= '0;
            for (int r = 0; r < BLK_ROWS; r++) begin
                s1_diff_q[r] <= '0;
                s2_sum_q[r]  <= '0;
            end
        end else begin
            idx_q     <= idx_d;
            // S1 accepts a new candidate even alongside start_i; later stages are flushed.
            s1_v_q    <= valid_i;
            s1_last_q <= valid_i & last_i;
            s1_idx_q  <= cand_idx;
            s1_diff_q <= diff_d;
            s2_v_q    <= s1_v_q & ~start_i;
            s2_last_q <= s1_last_q;
            s2_idx_q  <= s1_idx_q;
            s2_sum_q  <= rowsum_d;
            s3_v_q    <= s2_v_q & ~start_i;
            s3_last_q <= s2_last_q;
            s3_idx_q  <= s2_idx_q;
            s3_sad_q  <= total_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            first_q    <= 1'b1;
            min_sad_q  <= '0;
            min_idx_q  <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                // An S3 result sitting here belongs to the abandoned search; ignore it.
                first_q <= 1'b1;
            end else if (s3_v_q) begin
                first_q   <= 1'b0;
                min_sad_q <= cmp_sad;
                min_idx_q <= cmp_idx;
                if (s3_last_q) begin
                    best_sad_q <= cmp_sad;
                    best_idx_q <= cmp_idx;
                    done_q     <= 1'b1;
                end
            end
        end
    end

    assign sad_valid_o = s3_v_q;
    assign sad_o       = s3_sad_q;
    assign done_o      = done_q;
    assign best_sad_o  = best_sad_q;
    assign best_idx_o  = best_idx_q;

endmodule

// File: tb/tb_me_sad_min_search.sv
// Bench for me_sad_min_search: a stimulus table is built up front, a behavioural model derives
// per-cycle expectations from it, and one compare process checks the DUT every cycle.
module tb_me_sad_min_search;

    localparam int NCYC = 4000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cur_wr = 1'b0;
    logic [2:0]   cur_addr = '0;
    logic [127:0] cur_row = '0;
    logic         start = 1'b0, valid = 1'b0, last = 1'b0;
    logic [127:0] ref_r [8];
    logic         sad_valid, done;
    logic [14:0]  sad, best_sad;
    logic [7:0]   best_idx;

    always #5 clk = ~clk;

    me_sad_min_search #(.IDX_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cur_wr_i    (cur_wr),
        .cur_addr_i  (cur_addr),
        .cur_row_i   (cur_row),
        .start_i     (start),
        .valid_i     (valid),
        .last_i      (last),
        .ref_row0_i  (ref_r[0]),
        .ref_row1_i  (ref_r[1]),
        .ref_row2_i  (ref_r[2]),
        .ref_row3_i  (ref_r[3]),
        .ref_row4_i  (ref_r[4]),
        .ref_row5_i  (ref_r[5]),
        .ref_row6_i  (ref_r[6]),
        .ref_row7_i  (ref_r[7]),
        .sad_valid_o (sad_valid),
        .sad_o       (sad),
        .done_o      (done),
        .best_sad_o  (best_sad),
        .best_idx_o  (best_idx)
    );

    // Stimulus table
    bit         st [NCYC], vl [NCYC], ls [NCYC], wr [NCYC];
    bit [2:0]   wa [NCYC];
    bit [127:0] wd [NCYC];
    bit [127:0] rf [NCYC][8];
    int         pc = 0;

    // Expectations
    bit exp_sv [NCYC], exp_done [NCYC];
    int exp_sad [NCYC], done_sad [NCYC], done_idx [NCYC], exp_bs [NCYC], exp_bi [NCYC];

    typedef struct { int cyc; int kind; int val; } lit_t;
    lit_t lits[$];

    int  checks = 0, errors = 0;
    int  cyc = 0;
    bit  run = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit [127:0] rnd_row();
        bit [127:0] r;
        bit         wide = $urandom_range(0, 1) == 1;
        for (int p = 0; p < 16; p++) r[p*8 +: 8] = 8'($urandom_range(0, wide ? 255 : 3));
        return r;
    endfunction

    function automatic int row_sad(input bit [127:0] a, input bit [127:0] b);
        int s = 0;
        for (int p = 0; p < 16; p++) begin
            int x = int'(a[p*8 +: 8]);
            int y = int'(b[p*8 +: 8]);
            s += (x > y) ? x - y : y - x;
        end
        return s;
    endfunction

    task automatic add_cand(input bit s, input bit l, input bit [7:0] pix);
        st[pc] = s; vl[pc] = 1'b1; ls[pc] = l;
        for (int r = 0; r < 8; r++) rf[pc][r] = {16{pix}};
        pc++;
    endtask

    task automatic wr_cur(input bit [7:0] pix);
        for (int r = 0; r < 8; r++) begin
            wr[pc] = 1'b1; wa[pc] = 3'(r); wd[pc] = {16{pix}};
            pc++;
        end
    endtask

    task automatic add_lit(input int c, input int k, input int v);
        lit_t l;
        l.cyc = c; l.kind = k; l.val = v;
        lits.push_back(l);
    endtask

    task automatic build();
        int t;
        bit [127:0] prev [8];
        pc = 2;
        // identical blocks
        wr_cur(8'h01); t = pc; add_cand(1, 1, 8'h01); pc += 5;
        add_lit(t + 3, 0, 0); add_lit(t + 4, 1, 0); add_lit(t + 4, 2, 0);
        // max SAD
        wr_cur(8'h00); t = pc; add_cand(1, 1, 8'hFF); pc += 5;
        add_lit(t + 3, 0, 32640); add_lit(t + 4, 1, 32640);
        // minimum search: offsets 3,1,2,5
        wr_cur(8'h10); t = pc;
        add_cand(1, 0, 8'h13); add_cand(0, 0, 8'h11); add_cand(0, 0, 8'h12); add_cand(0, 1, 8'h15);
        pc += 5;
        add_lit(t + 3, 0, 384); add_lit(t + 4, 0, 128); add_lit(t + 5, 0, 256);
        add_lit(t + 6, 0, 640); add_lit(t + 7, 1, 128); add_lit(t + 7, 2, 1);
        // tie: offsets 2,1,1
        t = pc; add_cand(1, 0, 8'h12); add_cand(0, 0, 8'h11); add_cand(0, 1, 8'h11); pc += 5;
        add_lit(t + 6, 1, 128); add_lit(t + 6, 2, 1);
        // abort: two candidates flushed by a start, then offset 4 with last
        t = pc; add_cand(1, 0, 8'h11); add_cand(0, 0, 8'h12);
        st[pc] = 1'b1; pc++;
        add_cand(0, 1, 8'h14); pc += 5;
        add_lit(t + 7, 1, 512); add_lit(t + 7, 2, 0);
        // index wrap: candidate 257 (index 1 after wrap) matches exactly
        t = pc;
        for (int k = 0; k < 260; k++) add_cand(k == 0, k == 259, (k == 257) ? 8'h10 : 8'h30);
        pc += 5;
        add_lit(t + 263, 1, 0); add_lit(t + 263, 2, 1);
        // randomized searches
        for (int s = 0; s < 40; s++) begin
            int n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0) begin
                    ls[pc] = $urandom_range(0, 1) == 1;  // stray last without valid
                    pc++;
                end
                st[pc] = (k == 0) || ($urandom_range(0, 11) == 0);
                vl[pc] = 1'b1;
                ls[pc] = (k == n - 1);
                for (int r = 0; r < 8; r++) begin
                    if (!(k > 0 && $urandom_range(0, 2) == 0)) prev[r] = rnd_row();
                    rf[pc][r] = prev[r];
                end
                if ($urandom_range(0, 4) == 0) begin
                    wr[pc] = 1'b1; wa[pc] = 3'($urandom_range(0, 7)); wd[pc] = rnd_row();
                end
                pc++;
            end
            pc += $urandom_range(0, 6);
        end
        pc += 8;
    endtask

    // Model: derive outputs from search semantics over the whole table.
    task automatic model();
        bit [127:0] cm [8];
        int cnt = 0, mn = 0, mi = 0, bs = 0, bi = 0;
        bit have = 1'b0;
        for (int r = 0; r < 8; r++) cm[r] = '0;
        for (int c = 0; c < pc; c++) begin
            if (st[c]) begin cnt = 0; have = 1'b0; end
            if (vl[c]) begin
                int s = 0;
                int idx = cnt;
                for (int r = 0; r < 8; r++) s += row_sad(rf[c][r], cm[r]);
                cnt = (cnt + 1) % 256;
                if (!st[c+1] && !st[c+2]) begin
                    exp_sv[c+3] = 1'b1; exp_sad[c+3] = s;
                    if (!st[c+3]) begin
                        if (!have || s < mn) begin mn = s; mi = idx; have = 1'b1; end
                        if (ls[c]) begin
                            exp_done[c+4] = 1'b1; done_sad[c+4] = mn; done_idx[c+4] = mi;
                        end
                    end
                end
            end
            if (wr[c]) cm[wa[c]] = wd[c];
        end
        for (int c = 0; c < pc; c++) begin
            if (exp_done[c]) begin bs = done_sad[c]; bi = done_idx[c]; end
            exp_bs[c] = bs; exp_bi[c] = bi;
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("sad_valid", int'(sad_valid), int'(exp_sv[cyc]));
            if (exp_sv[cyc]) chk("sad", int'(sad), exp_sad[cyc]);
            chk("done", int'(done), int'(exp_done[cyc]));
            chk("best_sad", int'(best_sad), exp_bs[cyc]);
            chk("best_idx", int'(best_idx), exp_bi[cyc]);
            foreach (lits[i]) begin
                if (lits[i].cyc == cyc) begin
                    case (lits[i].kind)
                        0: begin
                            chk("lit_sad_valid", int'(sad_valid), 1);
                            chk("lit_sad", int'(sad), lits[i].val);
                        end
                        1: begin
                            chk("lit_done", int'(done), 1);
                            chk("lit_best_sad", int'(best_sad), lits[i].val);
                        end
                        default: chk("lit_best_idx", int'(best_idx), lits[i].val);
                    endcase
                end
            end
        end
    end

    task automatic apply(input int c);
        start = st[c]; valid = vl[c]; last = ls[c];
        cur_wr = wr[c]; cur_addr = wa[c]; cur_row = wd[c];
        for (int r = 0; r < 8; r++) ref_r[r] = rf[c][r];
    endtask

    task automatic idle_inputs();
        start = 1'b0; valid = 1'b0; last = 1'b0; cur_wr = 1'b0;
        for (int r = 0; r < 8; r++) ref_r[r] = '0;
    endtask

    initial begin
        idle_inputs();
        build();
        model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < pc; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            cyc = c;
            apply(c);
            run = 1'b1;
        end
        @(negedge clk);
        #1 run = 1'b0;

        // Asynchronous reset in the middle of a search
        @(posedge clk); #1 start = 1'b1; valid = 1'b1;
        for (int r = 0; r < 8; r++) ref_r[r] = {16{8'h22}};
        @(posedge clk); #1 start = 1'b0;
        for (int r = 0; r < 8; r++) ref_r[r] = {16{8'h33}};
        @(posedge clk); #1 idle_inputs();
        @(posedge clk); #2;
        chk("pre_rst_sad_valid", int'(sad_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_sad_valid", int'(sad_valid), 0);
        chk("rst_sad", int'(sad), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_best_sad", int'(best_sad), 0);
        chk("rst_best_idx", int'(best_idx), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_sad_valid", int'(sad_valid), 0);
        end
        // Current block was cleared by reset, so offset 7 against zero gives 7*128.
        @(posedge clk); #1 start = 1'b1; valid = 1'b1; last = 1'b1;
        for (int r = 0; r < 8; r++) ref_r[r] = {16{8'h07}};
        @(posedge clk); #1 idle_inputs();
        @(posedge clk);
        @(posedge clk); #1;
        chk("new_sad_valid", int'(sad_valid), 1);
        chk("new_sad", int'(sad), 896);
        chk("new_done_early", int'(done), 0);
        @(posedge clk); #1;
        chk("new_done", int'(done), 1);
        chk("new_best_sad", int'(best_sad), 896);
        chk("new_best_idx", int'(best_idx), 0);
        @(posedge clk); #1;
        chk("new_done_pulse", int'(done), 0);
        chk("new_best_hold", int'(best_sad), 896);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
